serial_full_adder: RTL and testbench
====================================

Name: serial_full_adder

Overview:
Bit-serial adder and the sequential responder for the full-adder stimulus interface. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It ripples them LSB-first through one full-adder cell, one bit per clock, then presents the sum word and carry-out through a valid/ready handshake. It is intended as the area-minimal arithmetic element behind interface-driven benches and serial datapaths.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A, sampled only on input handshake
b  input  WIDTH  operand B, sampled only on input handshake
c_in  input  1  carry-in, sampled only on input handshake
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result word
c_out  output  1  registered carry-out
busy  output  1  high in RUN or DONE
ovf  output  1  signed overflow; present only with OVERFLOW_EN

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, ovf=0. Internal shift registers, carry and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, capture a, b, c_in into the shift registers.
  - Load carry with c_in, set bit counter to 0, go to RUN.
- RUN: in_ready=0. Each edge:
  - s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one.
  - Shift s into the MSB of the sum shift register; increment the counter.
  - When the counter equals WIDTH-1 on an edge, that edge processes the final bit. It copies the completed word to sum, the final carry to c_out, and ovf if enabled, then goes to DONE.
- DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE.
- Latency: if the input handshake occurs at edge E, out_valid is 1 after edge E+WIDTH.
- Throughput: one operation per WIDTH+2 cycles minimum, with no overlap. in_ready is high only in IDLE.
- sum, c_out and ovf change only on the final RUN edge or on reset. They hold the last result through IDLE and the next RUN.
- in_valid while in_ready=0 is ignored; no queuing. out_ready outside DONE has no effect.
- WIDTH=1: exactly one RUN cycle; the result equals the full-adder truth table.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1).
- rst asserted in any state, including mid-RUN: the operation is discarded and the next state is IDLE with all reset values. No partial result is ever presented.

Optional Feature:
OVERFLOW_EN
- Defined: port ovf exists. On the final RUN edge, ovf <= (carry into MSB) XOR (carry out of MSB), which is two's-complement overflow. It is held with sum and cleared by reset.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=1, all 8 combinations of a/b/c_in, one at a time -> sum/c_out match the full-adder truth table (e.g. 1,1,1 -> sum=1, c_out=1); out_valid 1 cycle after each accept.
2. WIDTH=8, a=0x5A, b=0x3C, c_in=0 -> sum=0x96, c_out=0, ovf=1; out_valid exactly 8 cycles after the accept edge; in_ready=0 throughout.
3. WIDTH=8, a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1, ovf=0. Then a=0x7F, b=0x00, c_in=1 -> sum=0x80, c_out=0, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with a new op -> sum stable, out_valid stays 1, in_ready=0. The new op is accepted only on the first edge after returning to IDLE.
5. Assert rst for 1 cycle after 3 RUN edges -> next cycle IDLE, out_valid=0, sum=0, c_out=0. Then 0x01+0x01, c_in=0 -> sum=0x02, c_out=0.
6. Build without OVERFLOW_EN; rerun scenario 3 -> identical sum/c_out and timing, no ovf port.

Source files
------------

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first, one bit per clock.
// Optional OVERFLOW_EN macro adds the ovf port (two's-complement overflow of the result).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one operand bit added per clock, LSB first
// DONE  | result presented on sum/c_out; waits for out_ready
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             carry_next;
    logic             bit_s;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    // New bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = bit_s;
        end else begin : g_sum_wn
            assign sum_next = {bit_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (last_bit)  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= sum_next;
                        c_out <= carry_next;
`ifdef OVERFLOW_EN
                        // carry into the MSB cell vs. carry out of it
                        ovf   <= carry ^ carry_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder: WIDTH=1 truth table and WIDTH=8 operations.
// ovf is checked only when OVERFLOW_EN is defined.
module tb_serial_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8 instance
    logic       rst8, in_valid8, in_ready8, c_in8, out_valid8, out_ready8, c_out8, busy8;
    logic [7:0] a8, b8, sum8;
`ifdef OVERFLOW_EN
    logic       ovf8;
`endif

    // WIDTH=1 instance
    logic       rst1, in_valid1, in_ready1, c_in1, out_valid1, out_ready1, c_out1, busy1;
    logic [0:0] a1, b1, sum1;
`ifdef OVERFLOW_EN
    logic       ovf1;
`endif

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .c_out(c_out8),
`ifdef OVERFLOW_EN
        .ovf(ovf8),
`endif
        .busy(busy8)
    );

    serial_full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1),
`ifdef OVERFLOW_EN
        .ovf(ovf1),
`endif
        .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec8_t;

    vec8_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready8 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_in_ready8", {31'd0, in_ready8}, 32'd1);
    endtask

    // One full WIDTH=8 operation with exact latency and handshake checks.
    task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic [7:0] es, input logic ec, input logic eo);
        logic early;
        wait_ready8();
        in_valid8 = 1'b1; a8 = av; b8 = bv; c_in8 = cv;
        tick();
        in_valid8 = 1'b0; a8 = ~av; b8 = ~bv; c_in8 = ~cv;
        chk({name, "_busy"}, {31'd0, busy8}, 32'd1);
        early = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (out_valid8 || in_ready8) early = 1'b1;
            tick();
        end
        if (out_valid8 || in_ready8) early = 1'b1;
        chk({name, "_run_flags"}, {31'd0, early}, 32'd0);
        tick();
        chk({name, "_out_valid"}, {31'd0, out_valid8}, 32'd1);
        chk({name, "_sum"}, {24'd0, sum8}, {24'd0, es});
        chk({name, "_cout"}, {31'd0, c_out8}, {31'd0, ec});
`ifdef OVERFLOW_EN
        chk({name, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("unexpected");
`endif
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk({name, "_back_idle"}, {30'd0, out_valid8, in_ready8}, 32'd1);
    endtask

    initial begin
        logic [7:0] hold_sum;
        logic       stable;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
        tick();
        tick();
        rst8 = 1'b0; rst1 = 1'b0;

        chk("rst8_flags", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
        chk("rst8_result", {23'd0, c_out8, sum8}, 32'd0);
        chk("rst1_flags", {29'd0, in_ready1, out_valid1, busy1}, 32'b100);
`ifdef OVERFLOW_EN
        chk("rst8_ovf", {31'd0, ovf8}, 32'd0);
`endif

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp;
            exp = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            in_valid1 = 1'b1; a1 = i[2]; b1 = i[1]; c_in1 = i[0];
            tick();
            in_valid1 = 1'b0;
            chk("w1_accept", {30'd0, in_ready1, out_valid1}, 32'd0);
            tick();
            chk("w1_out_valid", {31'd0, out_valid1}, 32'd1);
            chk("w1_result", {30'd0, c_out1, sum1}, {30'd0, exp});
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end

        // WIDTH=8 vector table
        for (int i = 0; i < 7; i++)
            op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        // Backpressure in DONE with a pending new operation
        wait_ready8();
        in_valid8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; c_in8 = 1'b0;
        tick();
        a8 = 8'h11; b8 = 8'h22; c_in8 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("bp_done", {31'd0, out_valid8}, 32'd1);
        hold_sum = sum8;
        chk("bp_sum_first", {24'd0, hold_sum}, 32'h96);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!out_valid8 || in_ready8 || sum8 !== hold_sum) stable = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk("bp_idle", {30'd0, in_ready8, busy8}, 32'b10);
        tick();
        in_valid8 = 1'b0;
        chk("bp_accept", {30'd0, in_ready8, busy8}, 32'b01);
        for (int k = 0; k < 7; k++) tick();
        chk("bp_not_yet", {31'd0, out_valid8}, 32'd0);
        tick();
        chk("bp_second", {23'd0, out_valid8, sum8}, {23'd1, 8'h33});
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;

        // Reset mid-RUN discards the operation and clears the held result
        wait_ready8();
        in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h0F; c_in8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk("midrst_flags", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
        chk("midrst_result", {23'd0, c_out8, sum8}, 32'd0);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid8) stable = 1'b0;
        end
        chk("midrst_no_partial", {31'd0, stable}, 32'd1);
        op8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
